// File: rtl/tt_um_andrewdamasta_pkg.sv
// Shared constants for the tt_um_andrewdamasta PWM block.
//   reg_addr_e    : register addresses on uio_in[1:0]
//   RST_*         : register values after reset
//   UIO_OE_VAL    : fixed output-enable pattern for the bidirectional pins
package tt_um_andrewdamasta_pkg;

   typedef enum logic [1:0] {
      ADDR_DUTY     = 2'd0,
      ADDR_PERIOD   = 2'd1,
      ADDR_PRESCALE = 2'd2,
      ADDR_CTRL     = 2'd3
   } reg_addr_e;

   localparam logic [7:0] RST_DUTY     = 8'h00;
   localparam logic [7:0] RST_PERIOD   = 8'hFF;
   localparam logic [7:0] RST_PRESCALE = 8'h00;
   localparam logic [7:0] RST_CTRL     = 8'h00;

   localparam logic [7:0] UIO_OE_VAL   = 8'hF0;

   // CTRL bit positions
   localparam int unsigned CTRL_EN  = 0;
   localparam int unsigned CTRL_INV = 1;

endpackage

// File: rtl/tt_um_andrewdamasta_if.sv
// Interfaces for tt_um_andrewdamasta.
//   tt_um_andrewdamasta_if      : the Tiny Tapeout pin bundle (ena, ui_in, uio_in
//                                 driven by master; uo_out, uio_out, uio_oe driven
//                                 by slave, i.e. the design).
//   tt_um_andrewdamasta_core_if : configuration/status link between the register
//                                 file (ctrl) and the PWM engine (core).
interface tt_um_andrewdamasta_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input  uo_out, uio_out, uio_oe);
   modport slave  (input  ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

interface tt_um_andrewdamasta_core_if;
   logic [7:0] duty;
   logic [7:0] period;
   logic [7:0] prescale;
   logic       en;
   logic       inv;
   logic [7:0] cnt;
   logic       pwm;
   logic       wrap;

   modport ctrl (output duty, period, prescale, en, inv, input  cnt, pwm, wrap);
   modport core (input  duty, period, prescale, en, inv, output cnt, pwm, wrap);
endinterface

// File: rtl/tt_um_andrewdamasta_pwm_core.sv
// PWM engine: prescaler, period counter, duty compare and wrap pulse.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : core modport; configuration in, cnt/pwm/wrap out
module pwm_core (
   input  logic                       i_clk,
   input  logic                       i_rst,
   tt_um_andrewdamasta_core_if.core   bus
);

   logic [7:0] r_pcnt;
   logic [7:0] r_cnt;
   logic       r_pwm;
   logic       r_wrap;

   logic       w_tick;
   logic       w_at_top;

   // >= rather than == so a PERIOD/PRESCALE lowered below the running count
   // still wraps on the next tick instead of running to 255.
   assign w_tick   = (r_pcnt >= bus.prescale);
   assign w_at_top = (r_cnt  >= bus.period);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
         r_pwm  <= 1'b0;
         r_wrap <= 1'b0;
      end else if (!bus.en) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
         r_wrap <= 1'b0;
         r_pwm  <= bus.inv;
      end else begin
         r_pcnt <= w_tick ? '0 : r_pcnt + 8'd1;
         if (w_tick) begin
            r_cnt <= w_at_top ? '0 : r_cnt + 8'd1;
         end
         r_wrap <= w_tick & w_at_top;
         r_pwm  <= (r_cnt < bus.duty) ^ bus.inv;
      end
   end

   assign bus.cnt  = r_cnt;
   assign bus.pwm  = r_pwm;
   assign bus.wrap = r_wrap;

endmodule

// File: rtl/tt_um_andrewdamasta.sv
// Tiny Tapeout wrapper: register file, write-enable edge detect and output muxes
// around the PWM engine.
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, ACTIVE-HIGH despite the legacy name
//   ena     : design select, unused
//   ui_in   : write data
//   uio_in  : [1:0] addr, [2] we, [3] rdsel, [7:4] unused
//   uo_out  : rdsel=0 period counter, rdsel=1 register at addr
//   uio_out : [4] pwm, [5] wrap pulse, [6] CTRL.en, others 0
//   uio_oe  : constant F0
module tt_um_andrewdamasta
   import tt_um_andrewdamasta_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0] r_duty;
   logic [7:0] r_period;
   logic [7:0] r_prescale;
   logic [7:0] r_ctrl;
   logic       r_we_q;

   reg_addr_e  w_addr;
   logic       w_we;
   logic       w_rdsel;
   logic       w_wr_stb;
   logic [7:0] w_rd_data;
   logic       w_unused;

   assign w_addr   = reg_addr_e'(uio_in[1:0]);
   assign w_we     = uio_in[2];
   assign w_rdsel  = uio_in[3];
   assign w_wr_stb = w_we & ~r_we_q;
   assign w_unused = &{1'b0, ena, uio_in[7:4]};

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_duty     <= RST_DUTY;
         r_period   <= RST_PERIOD;
         r_prescale <= RST_PRESCALE;
         r_ctrl     <= RST_CTRL;
         r_we_q     <= 1'b0;
      end else begin
         r_we_q <= w_we;
         if (w_wr_stb) begin
            unique case (w_addr)
               ADDR_DUTY:     r_duty     <= ui_in;
               ADDR_PERIOD:   r_period   <= ui_in;
               ADDR_PRESCALE: r_prescale <= ui_in;
               ADDR_CTRL:     r_ctrl     <= ui_in;
            endcase
         end
      end
   end

   tt_um_andrewdamasta_core_if cbus ();

   assign cbus.duty     = r_duty;
   assign cbus.period   = r_period;
   assign cbus.prescale = r_prescale;
   assign cbus.en       = r_ctrl[CTRL_EN];
   assign cbus.inv      = r_ctrl[CTRL_INV];

   pwm_core u_core (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (cbus)
   );

   always_comb begin
      w_rd_data = '0;
      unique case (w_addr)
         ADDR_DUTY:     w_rd_data = r_duty;
         ADDR_PERIOD:   w_rd_data = r_period;
         ADDR_PRESCALE: w_rd_data = r_prescale;
         ADDR_CTRL:     w_rd_data = r_ctrl;
      endcase
   end

   assign uo_out  = w_rdsel ? w_rd_data : cbus.cnt;
   assign uio_out = {1'b0, r_ctrl[CTRL_EN], cbus.wrap, cbus.pwm, 4'b0000};
   assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_andrewdamasta.sv
// Self-checking bench for tt_um_andrewdamasta: directed scenarios plus a
// randomized register-write phase, all compared every cycle against a
// behavioural model of the PWM rules.
module tb_tt_um_andrewdamasta;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tt_um_andrewdamasta_if pins ();

   tt_um_andrewdamasta dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (pins.ena),
      .ui_in   (pins.ui_in),
      .uio_in  (pins.uio_in),
      .uo_out  (pins.uo_out),
      .uio_out (pins.uio_out),
      .uio_oe  (pins.uio_oe)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: register values and position in the PWM frame.
   int unsigned m_reg [4];
   int unsigned m_pcnt;
   int unsigned m_cnt;
   bit          m_pwm;
   bit          m_wrap;
   bit          m_we_prev;

   int n_high;
   int n_wrap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_reg[0]  = 32'h00;
      m_reg[1]  = 32'hFF;
      m_reg[2]  = 32'h00;
      m_reg[3]  = 32'h00;
      m_pcnt    = 0;
      m_cnt     = 0;
      m_pwm     = 1'b0;
      m_wrap    = 1'b0;
      m_we_prev = 1'b0;
   endtask

   // One clock edge of the specification's rules, using inputs present at the edge.
   task automatic model_step();
      bit en, inv, we;
      int unsigned duty, period, prescale, a;
      if (rst_n === 1'b1) begin
         model_reset();
         return;
      end
      en       = m_reg[3][0];
      inv      = m_reg[3][1];
      duty     = m_reg[0];
      period   = m_reg[1];
      prescale = m_reg[2];
      if (!en) begin
         m_pwm  = inv;
         m_wrap = 1'b0;
         m_pcnt = 0;
         m_cnt  = 0;
      end else begin
         m_pwm  = (m_cnt < duty) ^ inv;
         m_wrap = 1'b0;
         if (m_pcnt >= prescale) begin
            m_pcnt = 0;
            if (m_cnt >= period) begin
               m_cnt  = 0;
               m_wrap = 1'b1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else begin
            m_pcnt = m_pcnt + 1;
         end
      end
      we = pins.uio_in[2];
      a  = int'(pins.uio_in[1:0]);
      if (we && !m_we_prev) m_reg[a] = int'(pins.ui_in);
      m_we_prev = we;
   endtask

   function automatic logic [7:0] exp_uo();
      if (pins.uio_in[3]) return m_reg[int'(pins.uio_in[1:0])][7:0];
      return m_cnt[7:0];
   endfunction

   function automatic logic [7:0] exp_uio();
      return {1'b0, m_reg[3][0], m_wrap, m_pwm, 4'b0000};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("uo_out",  pins.uo_out,  exp_uo());
      check("uio_out", pins.uio_out, exp_uio());
      check("uio_oe",  pins.uio_oe,  8'hF0);
      if (pins.uio_out[4] === 1'b1) n_high++;
      if (pins.uio_out[5] === 1'b1) n_wrap++;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      pins.uio_in = {4'b0000, 1'b0, 1'b1, a};
      pins.ui_in  = d;
      cyc();
      pins.uio_in = {4'b0000, 1'b0, 1'b0, a};
      cyc();
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
      pins.uio_in = {4'b0000, 1'b1, 1'b0, a};
      cyc();
      check(tag, pins.uo_out, exp);
   endtask

   task automatic window(input int cycles, input int exp_high, input int exp_wrap, input string tag);
      n_high = 0;
      n_wrap = 0;
      repeat (cycles) cyc();
      check({tag, "_high"}, n_high, exp_high);
      check({tag, "_wrap"}, n_wrap, exp_wrap);
   endtask

   logic [7:0] rst_vals [4];

   initial begin
      rst_vals[0] = 8'h00;
      rst_vals[1] = 8'hFF;
      rst_vals[2] = 8'h00;
      rst_vals[3] = 8'h00;

      model_reset();
      pins.ena    = 1'b1;
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'h00;
      rst_n       = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b0;

      // Reset values and constant output enable
      check("rst_uo",  pins.uo_out,  8'h00);
      check("rst_uio", pins.uio_out, 8'h00);
      for (int i = 0; i < 4; i++) rd(2'(i), rst_vals[i], "rst_reg");

      // 4 high / 6 low, wrap every 10 cycles
      wr(2'd0, 8'h04);
      wr(2'd1, 8'h09);
      wr(2'd2, 8'h00);
      wr(2'd3, 8'h01);
      pins.uio_in = 8'h00;
      repeat (15) cyc();
      window(30, 12, 3, "p9_ps0");

      // Prescale 2: frame of 30 cycles, 12 high
      wr(2'd2, 8'h02);
      pins.uio_in = 8'h00;
      repeat (40) cyc();
      window(60, 24, 2, "p9_ps2");

      // Inverted output at duty extremes
      wr(2'd2, 8'h00);
      wr(2'd0, 8'h00);
      wr(2'd3, 8'h03);
      repeat (5) cyc();
      window(20, 20, 2, "inv_duty0");
      wr(2'd0, 8'h10);
      repeat (5) cyc();
      window(20, 0, 2, "inv_duty16");

      // Lowering PERIOD below the running count must wrap, not lock up
      wr(2'd3, 8'h01);
      wr(2'd1, 8'hC8);
      wr(2'd0, 8'h00);
      pins.uio_in = 8'h00;
      repeat (60) cyc();
      wr(2'd1, 8'h05);
      repeat (3) cyc();
      window(36, 0, 6, "period_lower");

      // Holding we writes only once
      pins.uio_in = {4'b0000, 1'b0, 1'b1, 2'd0};
      pins.ui_in  = 8'h11;
      cyc();
      for (int i = 0; i < 4; i++) begin
         pins.ui_in = 8'h22;
         cyc();
      end
      pins.uio_in = 8'h00;
      cyc();
      rd(2'd0, 8'h11, "we_hold");

      // Reset mid-count with a simultaneous write
      wr(2'd0, 8'h04);
      wr(2'd1, 8'h09);
      pins.uio_in = 8'h00;
      repeat (7) cyc();
      rst_n       = 1'b1;
      pins.uio_in = {4'b0000, 1'b0, 1'b1, 2'd1};
      pins.ui_in  = 8'h55;
      cyc();
      rst_n       = 1'b0;
      pins.uio_in = 8'h00;
      check("midrst_cnt", pins.uo_out,  8'h00);
      check("midrst_uio", pins.uio_out, 8'h00);
      for (int i = 0; i < 4; i++) rd(2'(i), rst_vals[i], "midrst_reg");

      // Randomized register traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [1:0] a;
         logic [7:0] d;
         a = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         if (a == 2'd1) d = 8'($urandom_range(0, 15));
         if (a == 2'd2) d = 8'($urandom_range(0, 3));
         if (a == 2'd0) d = 8'($urandom_range(0, 18));
         if (a == 2'd3) d[0] = ($urandom_range(0, 3) != 0);
         pins.ui_in  = d;
         pins.uio_in = {4'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), a};
         rst_n       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst_n = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tt_um_andrewdamasta.md
TT_UM_ANDREWDAMASTA -- requirements
Module: tt_um_andrewdamasta

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high. Port rst_n keeps the codebase name but is active-high: rst_n=1 at a clk rising edge resets.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous active-high reset.
REQ-004 ena  in  1  design-select; ignored, no functional effect.
REQ-005 ui_in  in  8  write data for register writes.
REQ-006 uio_in  in  8  [1:0]=addr, [2]=we, [3]=rdsel; [7:4] ignored.
REQ-007 uo_out  out  8  rdsel=0: period counter value; rdsel=1: register at addr.
REQ-008 uio_out  out  8  [4]=pwm, [5]=wrap pulse, [6]=CTRL.en, [7] and [3:0]=0.
REQ-009 uio_oe  out  8  constant 8'hF0.

Function
REQ-010 Registers, 8 bit each: addr 0 DUTY, 1 PERIOD, 2 PRESCALE, 3 CTRL (bit0 en, bit1 inv, bits[7:2] read as written).
REQ-011 we is edge-detected: a write occurs only on the cycle where we=1 and we was 0 on the previous cycle; holding we high writes once.
REQ-012 A write loads ui_in into the addressed register; the new value is visible on uo_out and used by counters from the next cycle.
REQ-013 Prescaler pcnt counts 0..PRESCALE; tick when pcnt>=PRESCALE, then pcnt<=0. PRESCALE=0 ticks every cycle.
REQ-014 Period counter cnt advances on tick only; when cnt>=PERIOD at a tick it wraps to 0, otherwise it increments.
REQ-015 Wrap pulse (uio_out[5]) is registered: high for exactly one cycle, the cycle after a tick with cnt>=PERIOD.
REQ-016 pwm is registered: pwm <= (en & (cnt < DUTY)) ^ inv; one cycle latency from cnt.
REQ-017 DUTY=0: pwm constant inv. DUTY>PERIOD: pwm constant ~inv while enabled (100%).
REQ-018 Lowering PERIOD or PRESCALE below the current count wraps at the next tick (>= compare); no lock-up.
REQ-019 en=0: pcnt and cnt held at 0, wrap pulse 0, pwm=inv; setting en=1 starts counting from 0 the next cycle.
REQ-020 uo_out and uio_out[6] are combinational from registers and uio_in[3:0]; no latency.
REQ-021 Unsigned 8-bit arithmetic only; no overflow beyond wrap rules above.

Reset
REQ-022 On rst_n=1: DUTY=00, PERIOD=FF, PRESCALE=00, CTRL=00, pcnt=0, cnt=0, pwm=0, wrap=0, we history=0.
REQ-023 Reset wins over a simultaneous write; outputs after reset: uo_out=00 (rdsel=0), uio_out=00, uio_oe=F0.
REQ-024 Reset mid-operation aborts counting immediately at that edge; no partial state survives.

Structure
REQ-025 Package tt_um_andrewdamasta_pkg holds register address constants, reset values, and the uio_oe constant.
REQ-026 One sub-module pwm_core (prescaler, period counter, compare, wrap pulse); top holds register file, edge detect, and output muxes.

Verification
REQ-027 Reset, rdsel=1, addr 0..3 -> uo_out reads 00, FF, 00, 00; uio_oe=F0.
REQ-028 Write DUTY=04, PERIOD=09, PRESCALE=00, CTRL=01 -> pwm high 4 cycles, low 6, repeating; wrap pulse every 10 cycles.
REQ-029 Same with PRESCALE=02 -> cnt steps every 3 cycles; pwm period 30 cycles, high 12.
REQ-030 CTRL=03 (inv) with DUTY=00 -> pwm constant 1; DUTY=10, PERIOD=09 -> pwm constant 0.
REQ-031 Hold we high 5 cycles while ui_in changes 11->22 -> register holds 11.
REQ-032 Assert rst_n mid-count with simultaneous write -> next cycle all registers at reset values, counters 0.
